// File: rtl/load_store_unit.sv
// Load/store stage in front of a big-endian, word-wide data memory. Sub-word stores use read-modify-write.
// Optional macro LSU_BOUNDS_CHECK_EN rejects accesses to words that lie past MEM_BYTES.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q, merge_q, merge_d, rdata_q, rdata_d;
  logic [1:0]  size_q;
  logic        signed_q, wr_q, err_q, err_d;
  logic        accept, reqErr;
  logic [31:0] alignedAddr;

  assign accept      = req_valid && req_ready;
  assign alignedAddr = {addr_q[31:2], 2'b00};

  function automatic logic [31:0] extractLane(input logic [31:0] d, input logic [1:0] off,
                                              input logic [1:0] size, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'h00;
    h = off[1] ? d[15:0] : d[31:16];
    case (off)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    case (size)
      2'b00:   extractLane = sgn ? {{24{b[7]}}, b} : {24'h0, b};
      2'b01:   extractLane = sgn ? {{16{h[15]}}, h} : {16'h0, h};
      default: extractLane = d;
    endcase
  endfunction

  function automatic logic [31:0] mergeLane(input logic [31:0] d, input logic [31:0] w,
                                            input logic [1:0] off, input logic [1:0] size);
    logic [31:0] m;
    m = d;
    if (size == 2'b00) begin
      case (off)
        2'd0:    m[31:24] = w[7:0];
        2'd1:    m[23:16] = w[7:0];
        2'd2:    m[15:8]  = w[7:0];
        default: m[7:0]   = w[7:0];
      endcase
    end else if (off[1]) begin
      m[15:0] = w[15:0];
    end else begin
      m[31:16] = w[15:0];
    end
    mergeLane = m;
  endfunction

  // Misalignment, reserved size and (optionally) range are all judged on the incoming request.
  always_comb begin
    reqErr = 1'b0;
    case (req_size)
      2'b01:   reqErr = req_addr[0];
      2'b10:   reqErr = |req_addr[1:0];
      2'b11:   reqErr = 1'b1;
      default: reqErr = 1'b0;
    endcase
`ifdef LSU_BOUNDS_CHECK_EN
    if (({req_addr[31:2], 2'b00} + 32'd3) > (MEM_BYTES - 32'd1))
      reqErr = 1'b1;
`else
`endif
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          err_d = reqErr;
          if (reqErr)                 state_d = RESP;
          else if (!req_wr)           state_d = RD;
          else if (req_size == 2'b10) state_d = WR;
          else                        state_d = RMW_RD;
        end
      end
      RD: begin
        rdata_d = extractLane(mem_rdata, addr_q[1:0], size_q, signed_q);
        state_d = RESP;
      end
      RMW_RD: begin
        merge_d = mergeLane(mem_rdata, wdata_q, addr_q[1:0], size_q);
        state_d = WR;
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE) && !rst;
    resp_valid = (state_q == RESP);
    resp_err   = (state_q == RESP) && err_q;
    resp_rdata = rdata_q;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    case (state_q)
      RD, RMW_RD: begin
        mem_rd   = 1'b1;
        mem_addr = alignedAddr;
      end
      WR: begin
        mem_wr    = 1'b1;
        mem_addr  = alignedAddr;
        mem_wdata = (size_q == 2'b10) ? wdata_q : merge_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      err_q    <= 1'b0;
      merge_q  <= 32'h0;
      rdata_q  <= 32'h0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      if (accept) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        size_q   <= req_size;
        signed_q <= req_signed;
        wr_q     <= req_wr;
      end
    end
  end

  logic unusedWr;
  assign unusedWr = wr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected responses, a monitor pops and compares.
// A small big-endian word memory model sits behind the DUT and commits writes on the falling edge.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wr, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr;

  logic [31:0] tbMem [32];
  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          rdCnt = 0;
  int          wrCnt = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          expCycle;
    int          nRd;
    int          nWr;
  } exp_t;
  exp_t sbQ[$];

  load_store_unit #(.MEM_BYTES(128)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Memory model: combinational read, falling-edge write, address wraps inside 128 bytes.
  assign mem_rdata = tbMem[mem_addr[6:2]];
  initial begin
    for (int i = 0; i < 32; i++) tbMem[i] = 32'h0;
    tbMem[0]  = 32'h01020304;
    tbMem[5]  = 32'h11223344;
    tbMem[31] = 32'hCAFEF00D;
    forever begin
      @(negedge clk);
      if (mem_wr) tbMem[mem_addr[6:2]] = mem_wdata;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: tallies memory strobes per transaction and checks every completion against the queue head.
  always @(negedge clk) begin
    if (rst) begin
      rdCnt = 0;
      wrCnt = 0;
    end else begin
      if (mem_rd || mem_wr) checkOutput("rdWrExclusive", 32'(mem_rd && mem_wr), 32'h0);
      if (mem_rd) rdCnt++;
      if (mem_wr) wrCnt++;
      if (resp_valid) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedResp", 32'h1, 32'h0);
        end else begin
          exp_t e;
          e = sbQ.pop_front();
          checkOutput("respErr", 32'(resp_err), 32'(e.err));
          checkOutput("respRdata", resp_rdata, e.rdata);
          checkOutput("respCycle", 32'(cycle), 32'(e.expCycle));
          checkOutput("memRdCount", 32'(rdCnt), 32'(e.nRd));
          checkOutput("memWrCount", 32'(wrCnt), 32'(e.nWr));
        end
        rdCnt = 0;
        wrCnt = 0;
      end
    end
  end

  task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic expErr, input logic [31:0] expRdata,
                               input int lat, input int nRd, input int nWr);
    int waitCnt;
    waitCnt = 0;
    @(negedge clk);
    while (!req_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!req_ready) begin
      checkOutput("readyTimeout", 32'h0, 32'h1);
      return;
    end
    req_valid  = 1'b1;
    req_wr     = wr;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    sbQ.push_back('{expErr, expRdata, cycle + lat, nRd, nWr});
    @(posedge clk);
    #1 req_valid = 1'b0;
    waitCnt = 0;
    while (sbQ.size() != 0 && waitCnt < 10) begin
      @(negedge clk);
      waitCnt++;
    end
    if (sbQ.size() != 0) begin
      checkOutput("respTimeout", 32'h0, 32'h1);
      sbQ.delete();
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    checkOutput("rstReqReady", 32'(req_ready), 32'h0);
    checkOutput("rstRespValid", 32'(resp_valid), 32'h0);
    checkOutput("rstRespErr", 32'(resp_err), 32'h0);
    checkOutput("rstRespRdata", resp_rdata, 32'h0);
    checkOutput("rstMemRdWr", {30'h0, mem_rd, mem_wr}, 32'h0);
    checkOutput("rstMemAddr", mem_addr, 32'h0);
    checkOutput("rstMemWdata", mem_wdata, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    //              wr    size   sgn   addr      wdata         err   rdata         lat rd wr
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h00000000, 2, 0, 1);
    checkOutput("memWordStore", tbMem[4], 32'hDEADBEEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF, 2, 1, 0);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000A5, 1'b0, 32'hDEADBEEF, 3, 1, 1);
    checkOutput("memByteStore", tbMem[4], 32'hDEA5BEEF);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h11, 32'h0,        1'b0, 32'hFFFFFFA5, 2, 1, 0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h11, 32'h0,        1'b0, 32'h000000A5, 2, 1, 0);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        1'b0, 32'hFFFFBEEF, 2, 1, 0);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD1234, 1'b0, 32'hFFFFBEEF, 3, 1, 1);
    checkOutput("memHalfStore", tbMem[4], 32'hDEA51234);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        1'b0, 32'h0000DEA5, 2, 1, 0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        1'b0, 32'h00000034, 2, 1, 0);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h10, 32'h0,        1'b0, 32'hFFFFFFDE, 2, 1, 0);

    // Rejected requests: misaligned half, misaligned word store, reserved size.
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h13, 32'h0,        1'b1, 32'hFFFFFFDE, 1, 0, 0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h12, 32'h55555555, 1'b1, 32'hFFFFFFDE, 1, 0, 0);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h10, 32'h66666666, 1'b1, 32'hFFFFFFDE, 1, 0, 0);
    checkOutput("memAfterErrors", tbMem[4], 32'hDEA51234);

    applyStimulus(1'b0, 2'b10, 1'b0, 32'h7C, 32'h0,        1'b0, 32'hCAFEF00D, 2, 1, 0);
`ifdef LSU_BOUNDS_CHECK_EN
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h80, 32'h0,        1'b1, 32'hCAFEF00D, 1, 0, 0);
`else
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h80, 32'h0,        1'b0, 32'h01020304, 2, 1, 0);
`endif

    // Reset lands in WR of a byte store, before the falling edge that would commit it.
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h15; req_wdata = 32'h00000077;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 checkOutput("wrStateReached", 32'(mem_wr), 32'h1);
    rst = 1'b1;
    #1 checkOutput("wrDropOnReset", 32'(mem_wr), 32'h0);
    checkOutput("readyLowInReset", 32'(req_ready), 32'h0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("memUnchangedAfterReset", tbMem[5], 32'h11223344);
    checkOutput("readyAfterReset", 32'(req_ready), 32'h1);
    checkOutput("rdataAfterReset", resp_rdata, 32'h0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h14, 32'h0,        1'b0, 32'h11223344, 2, 1, 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage placed directly upstream of the data memory. It receives load/store requests from the execute stage and handles byte, halfword and word sizes with big-endian lanes. Loads are sign- or zero-extended. Sub-word stores use read-modify-write, because the memory only writes whole 4-byte groups. The data memory reads combinationally, writes on the falling clock edge, and is byte-addressed big-endian: addr holds bits 31:24.

Parameters:
MEM_BYTES, 128, bytes of backing data memory; used only by the bounds check.

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  unit idle and able to accept
req_wr  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_signed  in  1  loads: 1 = sign-extend, 0 = zero-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified for byte/half
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  valid with resp_valid; misaligned, reserved size, or out of bounds
resp_rdata  out  32  extended load data
mem_addr  out  32  word-aligned address to data memory
mem_wdata  out  32  write data to data memory
mem_rd  out  1  memory read enable
mem_wr  out  1  memory write enable
mem_rdata  in  32  data memory read data

Behaviour:
- States: IDLE, RD, RMW_RD, WR, RESP. All outputs decode from state and latched request registers.
- Reset: state goes to IDLE asynchronously. While rst is high: req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
- req_ready = (state==IDLE) && !rst.
- Accept: at a rising edge with req_valid && req_ready. Latch addr, size, signed, wr and wdata.
- Error check at accept: error if size==11, half with addr[0]!=0, or word with addr[1:0]!=0. On error go to RESP with err=1; no memory access occurs.
- Transitions from IDLE after a valid accept:
  - load goes to RD
  - word store goes to WR
  - byte/half store goes to RMW_RD
- RD: mem_rd=1, mem_addr={addr[31:2],2'b00}. At the edge, extract the lane and extend it into resp_rdata, then go to RESP.
  - Byte lane: offset 0 is bits 31:24, offset 3 is bits 7:0.
  - Half lane: offset 0 is bits 31:16, offset 2 is bits 15:0.
- RMW_RD: mem_rd=1 with the same aligned address. At the edge, capture mem_rdata into the merge register with the target lane replaced by the low bits of wdata, then go to WR.
- WR: mem_wr=1, mem_wdata = merge register (sub-word) or wdata (word), aligned address. Go to RESP. The memory commits at the falling edge inside WR.
- RESP: resp_valid=1 for exactly one cycle, resp_err as latched, then go to IDLE. No accept occurs in RESP.
- Latency from accept edge to resp_valid high:
  - error: 1 cycle
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- Outside their states: mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0. mem_rd and mem_wr are never high together.
- resp_rdata changes only on a successful load completion and holds otherwise.
- Reset during WR before the falling edge drops mem_wr immediately, so no write occurs. Reset during RMW_RD discards the merge.
- Address arithmetic wraps mod 2^32. No carry into the upper bits.

Optional Feature:
LSU_BOUNDS_CHECK_EN.
- Defined: at accept, if {addr[31:2],2'b00}+3 > MEM_BYTES-1, flag an error with the same path and timing as a misalignment. No memory access occurs.
- Undefined: no range check; any aligned address reaches memory.

Test Plan:
- Word store addr 0x10 data 0xDEADBEEF, then word load at 0x10 -> store resp at accept+2 with err=0; load resp at accept+2 with resp_rdata=0xDEADBEEF.
- Byte store addr 0x11 data 0x000000A5 over word 0xDEADBEEF -> mem_rd seen in cycle 1, mem_wr in cycle 2 with mem_wdata=0xDEA5BEEF; resp at accept+3.
- Signed byte load at 0x11 of word 0xDEA5BEEF -> 0xFFFFFFA5; unsigned -> 0x000000A5; signed half at 0x12 -> 0xFFFFBEEF.
- Half load at 0x13, word store at 0x12, size 11 -> resp_err=1 at accept+1; mem_rd and mem_wr stay 0; memory contents unchanged.
- Assert rst during the WR state of a byte store before the falling edge -> mem_wr drops immediately, memory is unchanged, and req_ready=1 after release.
- With LSU_BOUNDS_CHECK_EN and MEM_BYTES=128: word load at 0x7C -> err=0; word load at 0x80 -> resp_err=1 with no memory access. Without the macro, address 0x80 asserts mem_rd.
